// File: rtl/mdu_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULS = 2'b00,
    OP_MULU = 2'b01,
    OP_DIVS = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Counter must hold 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mdu_sign_unit.sv
// Sign handling for the MDU: operand magnitudes at accept, result negation at FIX.
module mdu_sign_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               abs_en,
  output logic [WIDTH-1:0]   a_abs,
  output logic [WIDTH-1:0]   b_abs,
  output logic               a_neg,
  output logic               b_neg,
  input  logic [2*WIDTH-1:0] wide_in,
  input  logic               wide_neg_en,
  output logic [2*WIDTH-1:0] wide_out,
  input  logic [WIDTH-1:0]   q_in,
  input  logic               q_neg_en,
  output logic [WIDTH-1:0]   q_out,
  input  logic [WIDTH-1:0]   r_in,
  input  logic               r_neg_en,
  output logic [WIDTH-1:0]   r_out
);

  always_comb begin
    a_neg    = abs_en & a_in[WIDTH-1];
    b_neg    = abs_en & b_in[WIDTH-1];
    a_abs    = a_neg ? (~a_in + WIDTH'(1)) : a_in;
    b_abs    = b_neg ? (~b_in + WIDTH'(1)) : b_in;
    wide_out = wide_neg_en ? (~wide_in + (2*WIDTH)'(1)) : wide_in;
    q_out    = q_neg_en ? (~q_in + WIDTH'(1)) : q_in;
    r_out    = r_neg_en ? (~r_in + WIDTH'(1)) : r_in;
  end

endmodule

// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
module iter_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   oper_q, oper_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_p_q, neg_p_d;
  logic               neg_r_q, neg_r_d;
  logic               div0_q, div0_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               a_neg, b_neg;
  logic [ACC_W-1:0]   prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               div_ge;
  logic [ACC_W-1:0]   acc_mul_nxt, acc_div_nxt;

  mdu_sign_unit #(.WIDTH(WIDTH)) u_sign (
    .a_in        (a),
    .b_in        (b),
    .abs_en      (~op[0]),
    .a_abs       (a_abs),
    .b_abs       (b_abs),
    .a_neg       (a_neg),
    .b_neg       (b_neg),
    .wide_in     (acc_q),
    .wide_neg_en (neg_p_q),
    .wide_out    (prod_fix),
    .q_in        (acc_q[WIDTH-1:0]),
    .q_neg_en    (neg_p_q),
    .q_out       (quo_fix),
    .r_in        (acc_q[ACC_W-1:WIDTH]),
    .r_neg_en    (neg_r_q),
    .r_out       (rem_fix)
  );

  // One iteration step: acc = {upper, lower}; mul shifts the multiplier out of lower,
  // div shifts the dividend into the remainder held in upper.
  always_comb begin
    mul_sum     = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : '0);
    acc_mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh      = acc_q[ACC_W-1:WIDTH-1];
    div_ge      = (rem_sh >= {1'b0, oper_q});
    rem_diff    = rem_sh[WIDTH-1:0] - oper_q;
    acc_div_nxt = {(div_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      oper_q   <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      oper_q   <= oper_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    oper_d   = oper_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == FIX);
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d    = '0;
          a_raw_d  = a;
          is_div_d = op[1];
          neg_p_d  = a_neg ^ b_neg;
          if (op[1]) begin
            acc_d   = {{WIDTH{1'b0}}, a_abs};
            oper_d  = b_abs;
            neg_r_d = a_neg;
            div0_d  = (b == '0);
            ovf_d   = (op == OP_DIVS) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
          end else begin
            acc_d   = {{WIDTH{1'b0}}, b_abs};
            oper_d  = a_abs;
            neg_r_d = 1'b0;
            div0_d  = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = is_div_q ? acc_div_nxt : acc_mul_nxt;
      end
      FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else if (ovf_q) begin
          hi_d = '0;
          lo_d = a_raw_q;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
